// File: rtl/adc_controller_if.sv
// Bus bundle between adc_controller and its surroundings: request/mode inputs,
// the AD7608-style serial ADC pins, and the per-channel word stream.
interface adc_controller_if #(
    parameter int unsigned W_DATA = 18,
    parameter int unsigned W_CHAN = 3
);
    logic                     cstart_in;
    logic [2:0]               os_in;
    logic                     adc_busy_in;
    logic                     adc_data_a_in;
    logic                     adc_data_b_in;
    logic [2:0]               adc_os_out;
    logic                     adc_convst_out;
    logic                     adc_cs_out;
    logic                     adc_sclk_out;
    logic signed [W_DATA-1:0] data_out;
    logic [W_CHAN-1:0]        chan_out;
    logic                     data_valid_out;
    logic                     cycle_done_out;
    logic                     timeout_out;

    modport master (
        input  cstart_in, os_in, adc_busy_in, adc_data_a_in, adc_data_b_in,
        output adc_os_out, adc_convst_out, adc_cs_out, adc_sclk_out,
        output data_out, chan_out, data_valid_out, cycle_done_out, timeout_out
    );

    modport slave (
        output cstart_in, os_in, adc_busy_in, adc_data_a_in, adc_data_b_in,
        input  adc_os_out, adc_convst_out, adc_cs_out, adc_sclk_out,
        input  data_out, chan_out, data_valid_out, cycle_done_out, timeout_out
    );
endinterface

// File: rtl/adc_controller.sv
// Two-line serial ADC controller: convst/busy handshake, dual-line deserialiser,
// and a channel-tagged word stream (A word then B word per word slot).
module adc_controller #(
    parameter int unsigned W_DATA       = 18,
    parameter int unsigned N_CHAN       = 8,
    parameter int unsigned W_CHAN       = 3,
    parameter int unsigned T_CONVST     = 4,
    parameter int unsigned SCLK_HALF    = 2,
    parameter int unsigned BUSY_TIMEOUT = 64
) (
    input  logic             clk_in,
    input  logic             reset_in,
    adc_controller_if.master bus
);

    localparam int unsigned N_HALF = N_CHAN / 2;
    localparam int unsigned W_CNT  = $clog2(T_CONVST + BUSY_TIMEOUT + 1);
    localparam int unsigned W_HALF = $clog2(SCLK_HALF + 1);
    localparam int unsigned W_BIT  = $clog2(W_DATA + 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CONVST  = 3'd1;
    localparam logic [2:0] ST_WAIT_HI = 3'd2;
    localparam logic [2:0] ST_WAIT_LO = 3'd3;
    localparam logic [2:0] ST_READ    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    logic [2:0]        state,    state_d;
    logic [W_CNT-1:0]  cnt,      cnt_d;
    logic [W_HALF-1:0] half_cnt, half_d;
    logic [W_BIT-1:0]  bit_cnt,  bit_d;
    logic [W_CHAN-1:0] word_cnt, word_d;
    logic [W_DATA-1:0] sr_a,     sr_a_d;
    logic [W_DATA-1:0] sr_b,     sr_b_d;
    logic              emit_b,   emit_b_d;
    logic              convst_q, convst_d;
    logic              cs_q,     cs_d;
    logic              sclk_q,   sclk_d;
    logic [2:0]        os_q,     os_d;
    logic [W_DATA-1:0] data_q,   data_d;
    logic [W_CHAN-1:0] chan_q,   chan_d;
    logic              valid_q,  valid_d;
    logic              done_q,   done_d;
    logic              tmo_q,    tmo_d;

    // Next-state and next-output logic
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        half_d   = half_cnt;
        bit_d    = bit_cnt;
        word_d   = word_cnt;
        sr_a_d   = sr_a;
        sr_b_d   = sr_b;
        emit_b_d = 1'b0;
        convst_d = convst_q;
        cs_d     = cs_q;
        sclk_d   = sclk_q;
        os_d     = os_q;
        data_d   = data_q;
        chan_d   = chan_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        tmo_d    = tmo_q;

        case (state)
            ST_IDLE: begin
                os_d = bus.os_in;
                if (bus.cstart_in) begin
                    convst_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_CONVST;
                end
            end

            ST_CONVST: begin
                if (cnt == W_CNT'(T_CONVST - 1)) begin
                    convst_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_WAIT_HI;
                end else begin
                    cnt_d = cnt + W_CNT'(1);
                end
            end

            ST_WAIT_HI: begin
                if (bus.adc_busy_in) begin
                    state_d = ST_WAIT_LO;
                end else if (cnt == W_CNT'(BUSY_TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt + W_CNT'(1);
                end
            end

            ST_WAIT_LO: begin
                if (!bus.adc_busy_in) begin
                    cs_d    = 1'b0;
                    sclk_d  = 1'b0;
                    half_d  = '0;
                    bit_d   = '0;
                    word_d  = '0;
                    state_d = ST_READ;
                end
            end

            ST_READ: begin
                // Second strobe of a word slot: line-B word, which stays stable until the next rise
                if (emit_b) begin
                    data_d  = sr_b;
                    chan_d  = word_cnt + W_CHAN'(N_HALF);
                    valid_d = 1'b1;
                    if (word_cnt == W_CHAN'(N_HALF - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        word_d = word_cnt + W_CHAN'(1);
                    end
                end

                if (half_cnt == W_HALF'(SCLK_HALF - 1)) begin
                    half_d = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        sr_a_d = {sr_a[W_DATA-2:0], bus.adc_data_a_in};
                        sr_b_d = {sr_b[W_DATA-2:0], bus.adc_data_b_in};
                        if (bit_cnt == W_BIT'(W_DATA - 1)) begin
                            bit_d    = '0;
                            data_d   = sr_a_d;
                            chan_d   = word_cnt;
                            valid_d  = 1'b1;
                            emit_b_d = 1'b1;
                        end else begin
                            bit_d = bit_cnt + W_BIT'(1);
                        end
                    end
                end else begin
                    half_d = half_cnt + W_HALF'(1);
                end
            end

            ST_DONE: begin
                cs_d    = 1'b1;
                sclk_d  = 1'b1;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                convst_d = 1'b1;
                cs_d     = 1'b1;
                sclk_d   = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset releases the ADC bus immediately
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            sr_a     <= '0;
            sr_b     <= '0;
            emit_b   <= 1'b0;
            convst_q <= 1'b1;
            cs_q     <= 1'b1;
            sclk_q   <= 1'b1;
            os_q     <= '0;
            data_q   <= '0;
            chan_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            half_cnt <= half_d;
            bit_cnt  <= bit_d;
            word_cnt <= word_d;
            sr_a     <= sr_a_d;
            sr_b     <= sr_b_d;
            emit_b   <= emit_b_d;
            convst_q <= convst_d;
            cs_q     <= cs_d;
            sclk_q   <= sclk_d;
            os_q     <= os_d;
            data_q   <= data_d;
            chan_q   <= chan_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
        end
    end

    assign bus.adc_os_out     = os_q;
    assign bus.adc_convst_out = convst_q;
    assign bus.adc_cs_out     = cs_q;
    assign bus.adc_sclk_out   = sclk_q;
    assign bus.data_out       = data_q;
    assign bus.chan_out       = chan_q;
    assign bus.data_valid_out = valid_q;
    assign bus.cycle_done_out = done_q;
    assign bus.timeout_out    = tmo_q;

endmodule

// File: tb/tb_adc_controller.sv
// Directed bench for adc_controller with a behavioural two-line serial ADC.
module tb_adc_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;

    adc_controller_if #(.W_DATA(18), .W_CHAN(3)) bus ();

    adc_controller dut (
        .clk_in  (clk),
        .reset_in(rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ADC model: MSB-first words, bit pointer advances after each sclk rise
    logic [17:0] word_mem[8];
    int          bitn = 0;
    logic [17:0] wa, wb;
    int          widx, bpos;

    always @(posedge bus.adc_sclk_out or posedge bus.adc_cs_out)
        if (bus.adc_cs_out) bitn <= 0;
        else                bitn <= bitn + 1;

    always_comb begin
        widx = bitn / 18;
        bpos = 17 - (bitn % 18);
        wa   = '0;
        wb   = '0;
        if (widx < 4) begin
            wa = word_mem[widx];
            wb = word_mem[widx + 4];
        end
        bus.adc_data_a_in = wa[bpos];
        bus.adc_data_b_in = wb[bpos];
    end

    // Observers
    int          cyc = 0;
    logic [17:0] q_data[$];
    int          q_chan[$];
    int          last_valid_cyc = 0;
    int          convst_low = 0;
    int          n_sclk = 0;
    int          done_cyc = -1;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (bus.data_valid_out) begin
            q_data.push_back(bus.data_out);
            q_chan.push_back(int'(bus.chan_out));
            last_valid_cyc = cyc;
        end
        if (!bus.adc_convst_out) convst_low = convst_low + 1;
    end

    always @(posedge bus.adc_sclk_out) if (!bus.adc_cs_out) n_sclk = n_sclk + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        q_data.delete();
        q_chan.delete();
        convst_low = 0;
        n_sclk     = 0;
    endtask

    // Request a conversion, then play the busy pulse
    task automatic start_conv(input int busy_cyc);
        clear_obs();
        bus.cstart_in = 1'b1;
        tick(1);
        bus.cstart_in = 1'b0;
        check("convst_start", 32'(bus.adc_convst_out), 32'd0);
        for (int i = 0; i < 20 && !bus.adc_convst_out; i++) tick(1);
        bus.adc_busy_in = 1'b1;
        tick(busy_cyc);
        bus.adc_busy_in = 1'b0;
    endtask

    // mode 1: stray cstart mid-read; mode 2: os_in change mid-read
    task automatic wait_done(input int mode);
        int extra;
        done_cyc = -1;
        for (int i = 0; i < 2000; i++) begin
            if (mode == 1 && i == 50) begin
                check("cs_low_at_stray_req", 32'(bus.adc_cs_out), 32'd0);
                bus.cstart_in = 1'b1;
            end
            if (mode == 1 && i == 51) bus.cstart_in = 1'b0;
            if (mode == 2 && i == 50) bus.os_in = 3'd5;
            if (mode == 2 && i == 60) check("os_hold_mid", 32'(bus.adc_os_out), 32'd2);
            tick(1);
            if (bus.cycle_done_out) begin
                done_cyc = cyc;
                break;
            end
        end
        check("done_seen", 32'(done_cyc >= 0), 32'd1);
        check("cs_release", 32'(bus.adc_cs_out), 32'd1);
        check("sclk_release", 32'(bus.adc_sclk_out), 32'd1);
        if (mode == 1) begin
            extra = 0;
            for (int i = 0; i < 100; i++) begin
                tick(1);
                if (bus.cycle_done_out) extra++;
            end
            check("no_extra_done", 32'(extra), 32'd0);
        end
    endtask

    task automatic check_conv(input string tag);
        int order[8] = '{0, 4, 1, 5, 2, 6, 3, 7};
        check({tag, "_convst_low"}, 32'(convst_low), 32'd4);
        check({tag, "_sclk_rises"}, 32'(n_sclk), 32'd72);
        check({tag, "_n_strobes"}, 32'(q_data.size()), 32'd8);
        for (int i = 0; i < 8 && i < q_data.size(); i++) begin
            check($sformatf("%s_chan%0d", tag, i), 32'(q_chan[i]), 32'(order[i]));
            check($sformatf("%s_data%0d", tag, i), 32'(q_data[i]), 32'(word_mem[order[i]]));
        end
        check({tag, "_done_after_last"}, 32'(done_cyc - last_valid_cyc), 32'd1);
    endtask

    initial begin
        int n;
        bus.cstart_in   = 1'b0;
        bus.os_in       = 3'd2;
        bus.adc_busy_in = 1'b0;
        for (int k = 0; k < 8; k++) word_mem[k] = 18'h1_0000 + 18'(k);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_convst", 32'(bus.adc_convst_out), 32'd1);
        check("rst_cs", 32'(bus.adc_cs_out), 32'd1);
        check("rst_sclk", 32'(bus.adc_sclk_out), 32'd1);
        check("rst_valid", 32'(bus.data_valid_out), 32'd0);
        check("rst_done", 32'(bus.cycle_done_out), 32'd0);
        check("rst_timeout", 32'(bus.timeout_out), 32'd0);
        check("rst_data", 32'(unsigned'(bus.data_out)), 32'd0);
        check("rst_chan", 32'(bus.chan_out), 32'd0);
        check("rst_os", 32'(bus.adc_os_out), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(2);
        check("os_idle_latch", 32'(bus.adc_os_out), 32'd2);

        // Nominal conversion
        start_conv(20);
        wait_done(0);
        check_conv("nom");

        // Sign patterns pass through untouched
        word_mem[3] = 18'h2_0000;
        word_mem[6] = 18'h3_FFFF;
        start_conv(20);
        wait_done(0);
        check_conv("sign");

        // Busy never rises
        clear_obs();
        bus.cstart_in = 1'b1;
        tick(1);
        bus.cstart_in = 1'b0;
        n = 0;
        while (!bus.timeout_out && n < 200) begin
            tick(1);
            n++;
        end
        check("timeout_latency", 32'(n), 32'd68);
        tick(10);
        check("timeout_no_strobe", 32'(q_data.size()), 32'd0);
        check("timeout_cs_idle", 32'(bus.adc_cs_out), 32'd1);
        start_conv(20);
        wait_done(0);
        check_conv("after_tmo");
        check("timeout_sticky", 32'(bus.timeout_out), 32'd1);

        // Stray request during read is dropped
        start_conv(20);
        wait_done(1);
        check_conv("stray");

        // Back-to-back with an os_in change mid-read
        start_conv(20);
        wait_done(0);
        check_conv("b2b_first");
        start_conv(20);
        wait_done(2);
        check("os_hold_at_done", 32'(bus.adc_os_out), 32'd2);
        tick(1);
        check("os_after_idle", 32'(bus.adc_os_out), 32'd5);
        check_conv("b2b_second");

        // Reset in the middle of a read
        start_conv(20);
        tick(100);
        check("mid_read_cs", 32'(bus.adc_cs_out), 32'd0);
        for (int i = 0; i < 8 && bus.adc_sclk_out; i++) tick(1);
        check("mid_read_sclk_low", 32'(bus.adc_sclk_out), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_cs", 32'(bus.adc_cs_out), 32'd1);
        check("midrst_sclk", 32'(bus.adc_sclk_out), 32'd1);
        check("midrst_valid", 32'(bus.data_valid_out), 32'd0);
        check("midrst_timeout", 32'(bus.timeout_out), 32'd0);
        check("midrst_data", 32'(unsigned'(bus.data_out)), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(2);
        start_conv(20);
        wait_done(0);
        check_conv("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_controller.md
Name: adc_controller

Overview:
Drives a two-line serial simultaneous-sampling ADC (AD7608-style, 18-bit, 8 channels) and deserialises each conversion into per-channel words. Each output word is tagged with its channel index. It sits directly upstream of the per-channel oversample filters and supplies their data and data-valid inputs. One conversion runs per cstart_in request, and a done pulse marks the end of each full read cycle.

Parameters:
W_DATA, 18, ADC word width (bits per channel)
N_CHAN, 8, number of ADC channels; must be even; line A carries ch 0..N_CHAN/2-1, line B carries the rest
W_CHAN, 3, width of channel index (clog2 N_CHAN)
T_CONVST, 4, clk cycles convst_out is held low
SCLK_HALF, 2, clk cycles per sclk half-period (>=2)
BUSY_TIMEOUT, 64, max clk cycles to wait for busy to rise

Ports:
clk_in  in  1  system clock
reset_in  in  1  system reset; asynchronous, active-high
cstart_in  in  1  conversion request pulse (frontpanel or cycle timer)
os_in  in  3  ADC hardware oversample mode, passed through
adc_busy_in  in  1  ADC busy (high while converting)
adc_data_a_in  in  1  ADC serial data line A
adc_data_b_in  in  1  ADC serial data line B
adc_os_out  out  3  registered copy of os_in
adc_convst_out  out  1  convert start, active-low
adc_cs_out  out  1  chip select, active-low
adc_sclk_out  out  1  serial clock, idles high
data_out  out  W_DATA  signed channel word
chan_out  out  W_CHAN  channel index of data_out
data_valid_out  out  1  one-cycle strobe, data_out/chan_out valid
cycle_done_out  out  1  one-cycle strobe after the last channel of a conversion is emitted
timeout_out  out  1  sticky error flag: busy never rose

Behaviour:
- Reset (async, immediate):
  - convst, cs, sclk = 1; data_out, chan_out, adc_os_out = 0.
  - data_valid_out, cycle_done_out, timeout_out = 0.
  - State = ST_IDLE; all counters and shift registers = 0.
- Reset mid-read: the bus releases immediately (cs=1, sclk=1) and the partial conversion is discarded.
- adc_os_out latches os_in only in ST_IDLE.
- ST_IDLE:
  - On cstart_in=1: drive convst=0, reset counter, go to ST_CONVST.
  - cstart_in in any other state is ignored (not queued).
- ST_CONVST: hold convst=0 for exactly T_CONVST cycles, then convst=1 and go to ST_WAIT_HI.
- ST_WAIT_HI:
  - busy=1 -> ST_WAIT_LO.
  - BUSY_TIMEOUT cycles without busy -> set timeout_out=1, return to ST_IDLE; no data or done strobe.
- ST_WAIT_LO: busy=0 -> cs=0, go to ST_READ.
- ST_READ:
  - sclk = 0 for SCLK_HALF cycles, then 1 for SCLK_HALF cycles, repeating.
  - On the clk edge where sclk goes 0->1, shift adc_data_a_in and adc_data_b_in into separate W_DATA-bit shift registers, MSB first.
  - After each W_DATA bits (word index k = 0..N_CHAN/2-1):
    - Cycle t: data_out = A word, chan_out = k, data_valid_out = 1.
    - Cycle t+1: data_out = B word, chan_out = k + N_CHAN/2, data_valid_out = 1.
  - Shifting continues uninterrupted during emission; SCLK_HALF >= 2 guarantees no collision.
  - After the final B word is emitted: next cycle cs=1 and sclk=1, cycle_done_out=1 for one cycle, return to ST_IDLE.
- Total sclk rising edges per conversion = W_DATA*N_CHAN/2 (72 at defaults).
- data_out is the raw two's-complement ADC word; no extension.
- data_out/chan_out hold their last value between strobes.
- timeout_out is cleared only by reset_in.

Test Plan:
- Reset: assert reset_in mid-READ -> cs=1, sclk=1, data_valid_out=0 in the same cycle; the next cstart_in runs a clean full conversion.
- Nominal: ADC model returns ch k = 18'h1_0000 + k; pulse cstart, busy high for 20 cycles.
  - convst low exactly 4 cycles.
  - 72 sclk rising edges.
  - 8 strobes with chan order 0,4,1,5,2,6,3,7 and matching values.
  - cycle_done_out one cycle after the ch7 strobe.
- Sign: ch3 = 18'h2_0000 (-131072), ch6 = 18'h3_FFFF (-1) -> data_out shows those exact bit patterns.
- Timeout: cstart, busy never rises -> timeout_out=1 at 64 cycles after WAIT_HI entry; no data_valid; returns to idle; next good conversion still completes with timeout_out still 1.
- Ignored request: pulse cstart during ST_READ -> exactly 8 strobes and one done pulse, with no second conversion.
- Back-to-back: cstart on the cycle after cycle_done_out -> second conversion starts; os_in change mid-read appears on adc_os_out only after return to idle.
